// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART loopback path.
//   ASCII_CR / ASCII_LF : line-ending characters used by the CR->CRLF expander
//   loopback_state_t    : output FSM state of uart_loopback_fifo
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [0:0] {
        PASS,
        INSERT_LF
    } loopback_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO with first-word-fall-through head.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   push, push_data       : write one element (caller guarantees not full unless popping)
//   pop                   : remove head (caller guarantees not empty)
//   head                  : current head element, 0 when empty
//   level, level_next     : current and next-cycle occupancy
//   full, empty           : occupancy flags
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      head,
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     level_next,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q;

    always_comb begin
        level_next = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    assign level = level_q;
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    // Gate the head so the output reads 0 while nothing is stored.
    assign head  = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_next;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_loopback_fifo.sv
// uart_loopback_fifo: buffered bridge from uart_rx (valid/ready) to uart_tx (valid/ready).
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   in_data, in_valid, in_ready  : input stream from uart_rx
//   out_data, out_valid, out_ready : FWFT output stream to uart_tx
//   level                        : FIFO occupancy
//   overflow, drop_count         : sticky drop flag and saturating drop counter
//   clear_overflow               : clears overflow and drop_count (a same-cycle drop wins)
// Build option: define UART_LOOPBACK_CRLF_EN to expand each CR into CR LF on the output.
module uart_loopback_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned DROP_ON_FULL = 1,
    parameter int unsigned DROP_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    input  logic                    clear_overflow,
    output logic [DROP_WIDTH-1:0]   drop_count
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] head;
    logic [LVL_W-1:0]      level_next;
    logic                  push_fire, dropped;
    logic                  in_ready_q, in_ready_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (fifo_push),
        .push_data  (in_data),
        .pop        (fifo_pop),
        .head       (head),
        .level      (level),
        .level_next (level_next),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

`ifdef UART_LOOPBACK_CRLF_EN
    if (DATA_WIDTH != 8) begin : g_bad_width
        $error("uart_loopback_fifo: CRLF expansion requires DATA_WIDTH == 8");
    end

    loopback_state_t state_q, state_d;

    always_ff @(posedge clock) begin
        if (reset) state_q <= PASS;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        out_valid = !fifo_empty;
        out_data  = head;
        fifo_pop  = 1'b0;
        unique case (state_q)
            PASS: begin
                fifo_pop = !fifo_empty && out_ready;
                if (fifo_pop && head == DATA_WIDTH'(ASCII_CR)) state_d = INSERT_LF;
            end
            INSERT_LF: begin
                // LF is synthesised here; the FIFO head waits until it is sent.
                out_valid = 1'b1;
                out_data  = DATA_WIDTH'(ASCII_LF);
                if (out_ready) state_d = PASS;
            end
            default: state_d = PASS;
        endcase
    end
`else
    assign out_valid = !fifo_empty;
    assign out_data  = head;
    assign fifo_pop  = out_valid && out_ready;
`endif

    // Registered "not full" keeps in_ready free of any path from out_ready.
    assign in_ready  = in_ready_q && !reset;
    assign push_fire = in_valid && in_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign fifo_push = push_fire && (!fifo_full || fifo_pop);
    assign dropped   = push_fire && !fifo_push;

    always_comb begin
        in_ready_d = (DROP_ON_FULL != 0) ? 1'b1 : (level_next != LVL_W'(DEPTH));
    end

    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear_overflow) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
        if (dropped) begin
            overflow_d = 1'b1;
            if (drop_d != '1) drop_d = drop_d + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready_q <= 1'b1;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_uart_loopback_fifo.sv
module tb_uart_loopback_fifo;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Instance a: DEPTH=4, drop on full
    logic [7:0] a_in_data = '0;
    logic       a_in_valid = 1'b0, a_in_ready;
    logic [7:0] a_out_data;
    logic       a_out_valid, a_out_ready = 1'b0;
    logic [2:0] a_level;
    logic       a_overflow, a_clear = 1'b0;
    logic [7:0] a_drop;

    // Instance b: DEPTH=4, back-pressure
    logic [7:0] b_in_data = '0;
    logic       b_in_valid = 1'b0, b_in_ready;
    logic [7:0] b_out_data;
    logic       b_out_valid, b_out_ready = 1'b0;
    logic [2:0] b_level;
    logic       b_overflow;
    logic [7:0] b_drop;

    uart_loopback_fifo #(
        .DATA_WIDTH(8), .DEPTH(4), .DROP_ON_FULL(1), .DROP_WIDTH(8)
    ) u_dut_a (
        .clock(clock), .reset(reset),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .level(a_level), .overflow(a_overflow), .clear_overflow(a_clear),
        .drop_count(a_drop)
    );

    uart_loopback_fifo #(
        .DATA_WIDTH(8), .DEPTH(4), .DROP_ON_FULL(0), .DROP_WIDTH(8)
    ) u_dut_b (
        .clock(clock), .reset(reset),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .level(b_level), .overflow(b_overflow), .clear_overflow(1'b0),
        .drop_count(b_drop)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    int         model_level = 0;
    int         model_drop  = 0;
    logic       model_ovf   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: an output handshake seen here completes on the next rising edge.
    always @(negedge clock) begin
        if (!reset && a_out_valid && a_out_ready) begin
            if (exp_q.size() == 0) check_eq("a_unexpected_pop", {24'h0, a_out_data}, 32'hffff_ffff);
            else                   check_eq("a_pop_data", {24'h0, a_out_data}, {24'h0, exp_q.pop_front()});
        end
    end

    // One cycle on instance a, with the reference model updated alongside.
    task automatic a_cycle(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
        logic pop, acc;
        a_in_valid  = v;
        a_in_data   = d;
        a_out_ready = rdy;
        a_clear     = clr;
        pop = rdy && (model_level > 0);
        acc = v && ((model_level < 4) || pop);
        if (clr) begin
            model_ovf  = 1'b0;
            model_drop = 0;
        end
        if (acc) begin
            exp_q.push_back(d);
`ifdef UART_LOOPBACK_CRLF_EN
            if (d == 8'h0D) exp_q.push_back(8'h0A);
`endif
        end else if (v) begin
            model_ovf = 1'b1;
            if (model_drop < 255) model_drop++;
        end
        model_level = model_level + (acc ? 1 : 0) - (pop ? 1 : 0);
        step();
        a_in_valid = 1'b0;
        a_clear    = 1'b0;
    endtask

    task automatic a_drain(input string tag);
        a_out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!a_out_valid) break;
            step();
        end
        a_out_ready = 1'b0;
        model_level = 0;
        check_eq({tag, "_valid"}, {31'h0, a_out_valid}, 32'h0);
        check_eq({tag, "_left"}, exp_q.size(), 32'h0);
    endtask

    initial begin
        repeat (2) step();
        // Reset state
        check_eq("rst_in_ready", {31'h0, a_in_ready}, 32'h0);
        check_eq("rst_out_valid", {31'h0, a_out_valid}, 32'h0);
        check_eq("rst_out_data", {24'h0, a_out_data}, 32'h0);
        check_eq("rst_level", {29'h0, a_level}, 32'h0);
        check_eq("rst_overflow", {31'h0, a_overflow}, 32'h0);
        check_eq("rst_drop", {24'h0, a_drop}, 32'h0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready_a", {31'h0, a_in_ready}, 32'h1);
        check_eq("post_rst_in_ready_b", {31'h0, b_in_ready}, 32'h1);

        // In-order buffering with held head
        a_cycle(1'b1, 8'h41, 1'b0, 1'b0);
        check_eq("first_push_valid", {31'h0, a_out_valid}, 32'h1);
        a_cycle(1'b1, 8'h42, 1'b0, 1'b0);
        a_cycle(1'b1, 8'h43, 1'b0, 1'b0);
        check_eq("burst_level", {29'h0, a_level}, 32'h3);
        check_eq("burst_head", {24'h0, a_out_data}, 32'h41);
        repeat (2) step();
        check_eq("burst_head_hold", {24'h0, a_out_data}, 32'h41);
        a_drain("burst_drain");

        // Overflow with drop policy
        for (int i = 0; i < 6; i++) a_cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        check_eq("ovf_level", {29'h0, a_level}, 32'h4);
        check_eq("ovf_flag", {31'h0, a_overflow}, {31'h0, model_ovf});
        check_eq("ovf_drop", {24'h0, a_drop}, model_drop);
        a_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("clr_flag", {31'h0, a_overflow}, 32'h0);
        check_eq("clr_drop", {24'h0, a_drop}, 32'h0);

        // Full FIFO: push with simultaneous pop is accepted
        a_cycle(1'b1, 8'h20, 1'b1, 1'b0);
        check_eq("full_pushpop_level", {29'h0, a_level}, 32'h4);
        check_eq("full_pushpop_drop", {24'h0, a_drop}, model_drop);
        // Drop beats a same-cycle clear
        a_cycle(1'b1, 8'h21, 1'b0, 1'b1);
        check_eq("drop_vs_clr_flag", {31'h0, a_overflow}, 32'h1);
        check_eq("drop_vs_clr_count", {24'h0, a_drop}, 32'h1);
        a_drain("ovf_drain");

        // Back-pressure instance
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 8'h60 + 8'(i);
            step();
        end
        check_eq("bp_full_ready", {31'h0, b_in_ready}, 32'h0);
        check_eq("bp_full_level", {29'h0, b_level}, 32'h4);
        b_in_data = 8'h64;
        step();
        check_eq("bp_blocked_level", {29'h0, b_level}, 32'h4);
        check_eq("bp_no_overflow", {31'h0, b_overflow}, 32'h0);
        check_eq("bp_no_drop", {24'h0, b_drop}, 32'h0);
        check_eq("bp_head", {24'h0, b_out_data}, 32'h60);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        #1;
        check_eq("bp_ready_not_comb", {31'h0, b_in_ready}, 32'h0);
        step();
        b_out_ready = 1'b0;
        check_eq("bp_pop_level", {29'h0, b_level}, 32'h3);
        check_eq("bp_pop_ready", {31'h0, b_in_ready}, 32'h1);
        check_eq("bp_pop_head", {24'h0, b_out_data}, 32'h61);

        // CR handling (expanded to CR LF when the option is built in)
        a_cycle(1'b1, 8'h0D, 1'b0, 1'b0);
        a_cycle(1'b1, 8'h58, 1'b0, 1'b0);
        a_drain("cr_drain");

        // Reset mid-operation flushes everything
        for (int i = 0; i < 5; i++) a_cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        check_eq("pre_rst_overflow", {31'h0, a_overflow}, 32'h1);
        a_in_valid = 1'b1;
        a_in_data  = 8'h77;
        reset      = 1'b1;
        step();
        reset      = 1'b0;
        a_in_valid = 1'b0;
        exp_q.delete();
        model_level = 0;
        model_drop  = 0;
        model_ovf   = 1'b0;
        #1;
        check_eq("flush_level", {29'h0, a_level}, 32'h0);
        check_eq("flush_valid", {31'h0, a_out_valid}, 32'h0);
        check_eq("flush_overflow", {31'h0, a_overflow}, 32'h0);
        check_eq("flush_drop", {24'h0, a_drop}, 32'h0);
        check_eq("flush_in_ready", {31'h0, a_in_ready}, 32'h1);
        check_eq("flush_b_level", {29'h0, b_level}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
